// File: rtl/multicycle_control.sv
// Purpose : main control FSM of the multicycle MIPS datapath (fetch/decode/execute/mem/write-back).
// Latency : lw 5, sw 4, R-type 4, beq 3, j 3 cycles from FETCH entry to instr_done, plus stall cycles.
// Backpressure: mem_ready low holds FETCH, MEMRD and MEMWR with outputs frozen; no writes repeat.
//
// Ports: clk/rst_n (async active-low); opcode = IR[31:26]; mem_ready = memory completes this cycle.
//        Datapath enables/selects, ALUoperation class for the ALU control decoder, instr_done retire
//        pulse, sticky illegal_op, and the state encoding for debug.
// Build option: MC_JUMP_EN enables the j instruction (opcode 000010); without it j traps.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUoperation,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t state_q, state_d;
    logic   illegal_op_q, illegal_op_d;

    // Next-state logic. Unused encodings (and JUMP when jumps are compiled out) recover to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_EXEC;
                else if (opcode == OP_BEQ)              state_d = S_BEQ;
`ifdef MC_JUMP_EN
                else if (opcode == OP_J)                state_d = S_JUMP;
`endif
                else                                    state_d = S_TRAP;
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
`ifdef MC_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Sticky flag: set on the edge that enters TRAP, so it reads 1 throughout TRAP.
    always_comb begin
        illegal_op_d = illegal_op_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Output decode from the current state. Because state_q resets asynchronously to IDLE,
    // every output drops to 0 as soon as rst_n falls.
    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUoperation = 2'b00;
        instr_done   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Only capture IR / advance PC on the cycle memory actually delivers.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUoperation = 2'b10;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA      = 1'b1;
                ALUoperation = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                instr_done   = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign illegal_op = illegal_op_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : directed-vector bench for multicycle_control with a queue-based scoreboard.
// Latency : one vector per clock; expected state/outputs checked mid-cycle on the falling edge.
// Backpressure: mem_ready is driven per vector to create FETCH, MEMRD and MEMWR stalls.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUoperation;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .RegDst       (RegDst),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .PCSource     (PCSource),
        .ALUoperation (ALUoperation),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle, MSB first:
    // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegWrite RegDst ALUSrcA
    // ALUSrcB[2] PCSource[2] ALUoperation[2] instr_done illegal_op
    localparam logic [17:0] E_IDLE    = 18'd0;
    localparam logic [17:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_FETCH_S = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
    localparam logic [17:0] E_MEMWR_R = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
    localparam logic [17:0] E_MEMWR_S = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] E_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b10, 1'b0,1'b0};
    localparam logic [17:0] E_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
    localparam logic [17:0] E_BEQ     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b01, 1'b1,1'b0};
    localparam logic [17:0] E_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00, 1'b1,1'b0};
    localparam logic [17:0] E_TRAP    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [17:0] out;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic mr, input logic [5:0] op,
                       input logic [3:0] st, input logic [17:0] o);
        vec_t v;
        v.rst = r;
        v.mr  = mr;
        v.op  = op;
        v.st  = st;
        v.out = o;
        vecs.push_back(v);
    endtask

    // Monitor: the DUT presents a state/output bundle every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = sb.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
                   RegDst, ALUSrcA, ALUSrcB, PCSource, ALUoperation, instr_done, illegal_op};
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state vec %0d: got %0d expected %0d", e.idx, state, e.st);
            end
            checks++;
            if (act !== e.out) begin
                errors++;
                $display("FAIL outputs vec %0d (state %0d): got %b expected %b", e.idx, state, act, e.out);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = OP_R;

        // Reset held, then released: IDLE with all outputs 0.
        add(0, 1, OP_R, 4'd0, E_IDLE);
        add(0, 1, OP_R, 4'd0, E_IDLE);
        add(1, 1, OP_R, 4'd0, E_IDLE);
        // R-type: 1,2,7,8
        add(1, 1, OP_R, 4'd1, E_FETCH_R);
        add(1, 1, OP_R, 4'd2, E_DECODE);
        add(1, 1, OP_R, 4'd7, E_EXEC);
        add(1, 1, OP_R, 4'd8, E_RWB);
        // lw with two MEMRD stall cycles: 1,2,3,4,4,4,5
        add(1, 1, OP_LW, 4'd1, E_FETCH_R);
        add(1, 1, OP_LW, 4'd2, E_DECODE);
        add(1, 1, OP_LW, 4'd3, E_MEMADR);
        add(1, 0, OP_LW, 4'd4, E_MEMRD);
        add(1, 0, OP_LW, 4'd4, E_MEMRD);
        add(1, 1, OP_LW, 4'd4, E_MEMRD);
        add(1, 1, OP_LW, 4'd5, E_MEMWB);
        // sw with three FETCH stall cycles
        add(1, 0, OP_SW, 4'd1, E_FETCH_S);
        add(1, 0, OP_SW, 4'd1, E_FETCH_S);
        add(1, 0, OP_SW, 4'd1, E_FETCH_S);
        add(1, 1, OP_SW, 4'd1, E_FETCH_R);
        add(1, 1, OP_SW, 4'd2, E_DECODE);
        add(1, 1, OP_SW, 4'd3, E_MEMADR);
        add(1, 1, OP_SW, 4'd6, E_MEMWR_R);
        // beq (mem_ready low in BEQ must not matter)
        add(1, 1, OP_BEQ, 4'd1, E_FETCH_R);
        add(1, 1, OP_BEQ, 4'd2, E_DECODE);
        add(1, 0, OP_BEQ, 4'd9, E_BEQ);
        // j
        add(1, 1, OP_J, 4'd1, E_FETCH_R);
        add(1, 1, OP_J, 4'd2, E_DECODE);
`ifdef MC_JUMP_EN
        add(1, 1, OP_J, 4'd10, E_JUMP);
        add(1, 1, OP_BAD, 4'd1, E_FETCH_R);
        add(1, 1, OP_BAD, 4'd2, E_DECODE);
        add(1, 1, OP_BAD, 4'd11, E_TRAP);
        add(1, 0, OP_R, 4'd11, E_TRAP);
        add(1, 1, OP_R, 4'd11, E_TRAP);
`else
        add(1, 1, OP_J, 4'd11, E_TRAP);
        add(1, 0, OP_R, 4'd11, E_TRAP);
        add(1, 1, OP_R, 4'd11, E_TRAP);
`endif
        // Reset clears TRAP and illegal_op.
        add(0, 1, OP_R, 4'd0, E_IDLE);
        add(1, 1, OP_BAD, 4'd0, E_IDLE);
        add(1, 1, OP_BAD, 4'd1, E_FETCH_R);
        add(1, 1, OP_BAD, 4'd2, E_DECODE);
        add(1, 1, OP_BAD, 4'd11, E_TRAP);
        add(1, 1, OP_BAD, 4'd11, E_TRAP);
        add(0, 1, OP_R, 4'd0, E_IDLE);
        add(1, 1, OP_SW, 4'd0, E_IDLE);
        // sw stalled in MEMWR, then reset asserted mid-cycle while still in MEMWR.
        add(1, 1, OP_SW, 4'd1, E_FETCH_R);
        add(1, 1, OP_SW, 4'd2, E_DECODE);
        add(1, 1, OP_SW, 4'd3, E_MEMADR);
        add(1, 0, OP_SW, 4'd6, E_MEMWR_S);
        add(0, 0, OP_SW, 4'd0, E_IDLE);
        add(1, 1, OP_R, 4'd0, E_IDLE);
        // Recovery with another R-type.
        add(1, 1, OP_R, 4'd1, E_FETCH_R);
        add(1, 1, OP_R, 4'd2, E_DECODE);
        add(1, 1, OP_R, 4'd7, E_EXEC);
        add(1, 1, OP_R, 4'd8, E_RWB);
        add(1, 1, OP_R, 4'd1, E_FETCH_R);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst_n     = vecs[i].rst;
            mem_ready = vecs[i].mr;
            opcode    = vecs[i].op;
            e.idx = i;
            e.st  = vecs[i].st;
            e.out = vecs[i].out;
            sb.push_back(e);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
